// File: rtl/col_order_gen.sv
// ============================================================================
// Module   : col_order_gen
// Purpose  : Produces a detection column order by repeated unsigned minimum search.
// Revision : 1.0
// ============================================================================
`default_nettype none

module col_order_gen #(
    parameter int N = 8,
    parameter int W = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   norms,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*3-1:0]   colorder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SORT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] K_LAST = 3'(N - 1);

    state_t           state_q, state_d;
    logic [N*W-1:0]   norms_q, norms_d;
    logic [N-1:0]     used_q,  used_d;
    logic [2:0]       k_q,     k_d;
    logic [N*3-1:0]   order_q, order_d;

    logic             sel_found;
    logic [W-1:0]     sel_val;
    logic [2:0]       sel_idx;

    // Ascending scan with strict less-than keeps the lowest index on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_val   = '0;
        sel_idx   = '0;
        for (int c = 0; c < N; c++) begin
            if (!used_q[c] && (!sel_found || (norms_q[c*W +: W] < sel_val))) begin
                sel_found = 1'b1;
                sel_val   = norms_q[c*W +: W];
                sel_idx   = 3'(c);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        norms_d = norms_q;
        used_d  = used_q;
        k_d     = k_q;
        order_d = order_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    norms_d = norms;
                    used_d  = '0;
                    k_d     = '0;
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                for (int p = 0; p < N; p++) begin
                    if (k_q == 3'(p)) begin
                        order_d[p*3 +: 3] = sel_idx;
                    end
                end
                for (int c = 0; c < N; c++) begin
                    if (sel_idx == 3'(c)) begin
                        used_d[c] = 1'b1;
                    end
                end
                k_d = k_q + 3'd1;
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            norms_q <= '0;
            used_q  <= '0;
            k_q     <= '0;
            order_q <= '0;
        end else begin
            state_q <= state_d;
            norms_q <= norms_d;
            used_q  <= used_d;
            k_q     <= k_d;
            order_q <= order_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign colorder  = order_q;

endmodule

`default_nettype wire

// File: tb/tb_col_order_gen.sv
// ============================================================================
// Module   : tb_col_order_gen
// Purpose  : Scoreboard bench for col_order_gen with directed and throttled vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_col_order_gen;

    localparam int N = 8;
    localparam int W = 15;

    typedef int vec_t [N];

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*W-1:0]   norms = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [N*3-1:0]   colorder;

    int               checks   = 0;
    int               errors   = 0;
    int               accepted = 0;
    int               results  = 0;
    int               rdy_mode = 0;
    logic [N*3-1:0]   exp_q [$];
    logic [N-1:0]     mon_seen;

    col_order_gen #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .norms     (norms),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .colorder  (colorder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*3-1:0] pack_order(input vec_t e);
        logic [N*3-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*3 +: 3] = 3'(e[k]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] pack_norms(input vec_t n);
        logic [N*W-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*W +: W] = W'(n[c]);
        return r;
    endfunction

    // Stable insertion sort of column indices by norm value.
    function automatic logic [N*3-1:0] ref_order(input logic [N*W-1:0] v);
        vec_t idx;
        int   j;
        int   t;
        for (int i = 0; i < N; i++) idx[i] = i;
        for (int i = 1; i < N; i++) begin
            j = i;
            while (j > 0 && (v[idx[j-1]*W +: W] > v[idx[j]*W +: W])) begin
                t        = idx[j];
                idx[j]   = idx[j-1];
                idx[j-1] = t;
                j--;
            end
        end
        return pack_order(idx);
    endfunction

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 2) out_ready = 1'b0;
    end

    // Monitor: every presented result must be a permutation; handshakes pop the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            mon_seen = '0;
            for (int k = 0; k < N; k++) mon_seen[colorder[k*3 +: 3]] = 1'b1;
            chk("permutation", 64'(mon_seen), 64'({N{1'b1}}));
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no result", colorder);
                end else begin
                    chk("colorder", 64'(colorder), 64'(exp_q.pop_front()));
                    results++;
                end
            end
        end
    end

    task automatic send(input logic [N*W-1:0] v, input logic [N*3-1:0] e);
        logic ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        norms    = v;
        in_valid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        accepted++;
        #1;
        in_valid = 1'b0;
        norms    = (N*W)'({$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (out_valid) return;
            lat++;
        end
        checks++;
        errors++;
        $display("FAIL valid_timeout: got out_valid=0, expected 1");
    endtask

    initial begin
        vec_t             a;
        vec_t             b;
        int               lat;
        logic [N*3-1:0]   snap;
        logic [N*W-1:0]   v;
        int               r;
        logic             drained;

        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_colorder",  64'(colorder),  64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        a = '{70, 60, 50, 40, 30, 20, 10, 0};
        b = '{7, 6, 5, 4, 3, 2, 1, 0};
        send(pack_norms(a), pack_order(b));
        wait_valid(lat);
        chk("latency_descending", 64'(lat), 64'(N));
        @(negedge clk);
        chk("out_valid_one_cycle", 64'(out_valid), 64'd0);

        a = '{5, 5, 5, 5, 5, 5, 5, 5};
        b = '{0, 1, 2, 3, 4, 5, 6, 7};
        send(pack_norms(a), pack_order(b));
        wait_valid(lat);

        a = '{0, 0, 0, 32767, 0, 0, 0, 0};
        b = '{0, 1, 2, 4, 5, 6, 7, 3};
        send(pack_norms(a), pack_order(b));
        wait_valid(lat);

        // Downstream stall: output must freeze and new requests must be refused.
        @(negedge clk);
        rdy_mode = 2;
        a = '{3, 1, 4, 1, 5, 9, 2, 6};
        b = '{1, 3, 6, 0, 2, 4, 7, 5};
        send(pack_norms(a), pack_order(b));
        wait_valid(lat);
        snap = colorder;
        @(negedge clk);
        rdy_mode = 3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'(i % 2);
            norms    = (N*W)'({$urandom(), $urandom(), $urandom(), $urandom()});
            @(negedge clk);
            chk("stall_colorder",  64'(colorder),  64'(snap));
            chk("stall_in_ready",  64'(in_ready),  64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        a = '{2, 2, 1, 1, 0, 0, 3, 3};
        b = '{4, 5, 2, 3, 0, 1, 6, 7};
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        norms     = pack_norms(a);
        @(posedge clk);
        @(negedge clk);
        chk("handoff_in_ready",  64'(in_ready),  64'd1);
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        exp_q.push_back(pack_order(b));
        accepted++;
        #1;
        in_valid = 1'b0;
        norms    = '1;
        @(negedge clk);
        rdy_mode = 0;
        wait_valid(lat);
        chk("latency_after_stall", 64'(lat), 64'(N - 1));

        // Reset in the middle of sorting discards the result.
        a = '{9, 8, 7, 6, 5, 4, 3, 2};
        b = '{7, 6, 5, 4, 3, 2, 1, 0};
        send(pack_norms(a), pack_order(b));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midsort_rst_out_valid", 64'(out_valid), 64'd0);
        chk("midsort_rst_colorder",  64'(colorder),  64'd0);
        chk("midsort_rst_in_ready",  64'(in_ready),  64'd0);
        exp_q.delete();
        accepted--;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_no_valid", 64'(out_valid), 64'd0);
        a = '{100, 0, 32767, 7, 7, 1, 32766, 0};
        b = '{1, 7, 5, 3, 4, 0, 6, 2};
        send(pack_norms(a), pack_order(b));
        wait_valid(lat);
        chk("latency_post_rst", 64'(lat), 64'(N));

        // Throttled random traffic against the reference sort.
        @(negedge clk);
        rdy_mode = 1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            v = '0;
            for (int c = 0; c < N; c++) begin
                r = $urandom_range(0, 3);
                if (r == 0)      v[c*W +: W] = '0;
                else if (r == 1) v[c*W +: W] = '1;
                else if (r == 2) v[c*W +: W] = W'($urandom_range(0, 3));
                else             v[c*W +: W] = W'($urandom_range(0, 32767));
            end
            send(v, ref_order(v));
        end

        drained = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain", 64'(drained), 64'd1);
        chk("result_count", 64'(results), 64'(accepted));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
